// File: rtl/vid_timing_gen.sv
// Runtime-reprogrammable video timing generator: syncs, data enable, frame/line
// strobes and signed coordinates, with frame-boundary config switching and a line-compare strobe.
module vid_timing_gen #(
  parameter int CORDW  = 16,
  parameter int FCW    = 16,
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CORDW-1:0]        cfg_h_res,
  input  logic [CORDW-1:0]        cfg_h_fp,
  input  logic [CORDW-1:0]        cfg_h_sync,
  input  logic [CORDW-1:0]        cfg_h_bp,
  input  logic [CORDW-1:0]        cfg_v_res,
  input  logic [CORDW-1:0]        cfg_v_fp,
  input  logic [CORDW-1:0]        cfg_v_sync,
  input  logic [CORDW-1:0]        cfg_v_bp,
  input  logic                    cfg_h_pol,
  input  logic                    cfg_v_pol,
  output logic                    cfg_err,
  input  logic [CORDW-1:0]        irq_line,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame,
  output logic                    line,
  output logic                    line_irq,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic [FCW-1:0]          frame_cnt
);

  typedef struct packed {
    logic [CORDW-1:0] res;
    logic [CORDW-1:0] fp;
    logic [CORDW-1:0] sync;
    logic [CORDW-1:0] bp;
    logic             pol;
  } axis_t;

  localparam axis_t DEF_H = '{res: CORDW'(H_RES), fp: CORDW'(H_FP), sync: CORDW'(H_SYNC),
                              bp: CORDW'(H_BP), pol: H_POL};
  localparam axis_t DEF_V = '{res: CORDW'(V_RES), fp: CORDW'(V_FP), sync: CORDW'(V_SYNC),
                              bp: CORDW'(V_BP), pol: V_POL};
  localparam logic signed [CORDW-1:0] DEF_H_STA = CORDW'(-(H_FP + H_SYNC + H_BP));
  localparam logic signed [CORDW-1:0] DEF_V_STA = CORDW'(-(V_FP + V_SYNC + V_BP));
  localparam logic signed [CORDW-1:0] ONE = CORDW'(1);
  localparam logic [CORDW+1:0] MAX_TOTAL = {3'b000, {(CORDW-1){1'b1}}};

  // Unsigned fields are zero-extended before negation; validated totals fit CORDW-1 bits.
  function automatic logic signed [CORDW-1:0] f_sta(input axis_t a);
    logic [CORDW-1:0] blank;
    blank = a.fp + a.sync + a.bp;
    return -$signed(blank);
  endfunction

  function automatic logic signed [CORDW-1:0] f_hs_sta(input axis_t a);
    return f_sta(a) + $signed(a.fp);
  endfunction

  function automatic logic signed [CORDW-1:0] f_hs_end(input axis_t a);
    return f_hs_sta(a) + $signed(a.sync);
  endfunction

  function automatic logic signed [CORDW-1:0] f_a_end(input axis_t a);
    return $signed(a.res) - ONE;
  endfunction

  function automatic logic f_ok(input axis_t a);
    logic [CORDW+1:0] total;
    total = {2'b00, a.res} + {2'b00, a.fp} + {2'b00, a.sync} + {2'b00, a.bp};
    return (a.res != '0) && (a.sync != '0) && (total <= MAX_TOTAL);
  endfunction

  function automatic logic f_pol(input logic active, input logic pol);
    return active ? pol : !pol;
  endfunction

  axis_t act_h, act_v, shd_h, shd_v, cfg_h, cfg_v;
  logic  pending;
  logic signed [CORDW-1:0] x, y;
  logic signed [CORDW-1:0] h_sta, h_hs_sta, h_hs_end, h_a_end;
  logic signed [CORDW-1:0] v_sta, v_hs_sta, v_hs_end, v_a_end;
  logic xfer, cfg_ok, wrap, frame_now, line_now;

  assign cfg_h = '{res: cfg_h_res, fp: cfg_h_fp, sync: cfg_h_sync, bp: cfg_h_bp, pol: cfg_h_pol};
  assign cfg_v = '{res: cfg_v_res, fp: cfg_v_fp, sync: cfg_v_sync, bp: cfg_v_bp, pol: cfg_v_pol};

  assign h_sta    = f_sta(act_h);
  assign h_hs_sta = f_hs_sta(act_h);
  assign h_hs_end = f_hs_end(act_h);
  assign h_a_end  = f_a_end(act_h);
  assign v_sta    = f_sta(act_v);
  assign v_hs_sta = f_hs_sta(act_v);
  assign v_hs_end = f_hs_end(act_v);
  assign v_a_end  = f_a_end(act_v);

  assign cfg_ready = !pending;
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_ok    = f_ok(cfg_h) && f_ok(cfg_v);
  assign wrap      = (x == h_a_end) && (y == v_a_end);
  assign line_now  = (x == h_sta);
  assign frame_now = line_now && (y == v_sta);

  // Stage p0: position counters, active timing set and config shadow.
  // A config taken in a wrap cycle sees pending still low, so it waits a full frame.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      act_h   <= DEF_H;
      act_v   <= DEF_V;
      shd_h   <= '0;
      shd_v   <= '0;
      pending <= 1'b0;
      x       <= DEF_H_STA;
      y       <= DEF_V_STA;
    end else begin
      if (wrap && pending) begin
        act_h   <= shd_h;
        act_v   <= shd_v;
        x       <= f_sta(shd_h);
        y       <= f_sta(shd_v);
        pending <= 1'b0;
      end else if (x == h_a_end) begin
        x <= h_sta;
        y <= (y == v_a_end) ? v_sta : y + ONE;
      end else begin
        x <= x + ONE;
      end
      if (xfer && cfg_ok) begin
        shd_h   <= cfg_h;
        shd_v   <= cfg_v;
        pending <= 1'b1;
      end
    end
  end

  // Stage p1: registered outputs decoded from the p0 position and timing set.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      hsync     <= !H_POL;
      vsync     <= !V_POL;
      de        <= 1'b0;
      frame     <= 1'b0;
      line      <= 1'b0;
      line_irq  <= 1'b0;
      cfg_err   <= 1'b0;
      frame_cnt <= '0;
      sx        <= DEF_H_STA;
      sy        <= DEF_V_STA;
    end else begin
      hsync     <= f_pol((x > h_hs_sta) && (x <= h_hs_end), act_h.pol);
      vsync     <= f_pol((y > v_hs_sta) && (y <= v_hs_end), act_v.pol);
      de        <= !x[CORDW-1] && !y[CORDW-1];
      frame     <= frame_now;
      line      <= line_now;
      line_irq  <= line_now && (y == $signed(irq_line));
      cfg_err   <= xfer && !cfg_ok;
      frame_cnt <= frame_cnt + FCW'(frame_now);
      sx        <= x;
      sy        <= y;
    end
  end

endmodule

// File: doc/vid_timing_gen.md
Name: vid_timing_gen

Overview:
- Runtime-reprogrammable video timing generator that replaces the fixed 480p timing block in the HDMI display path.
- Produces hsync, vsync, de, frame and line strobes, plus signed screen coordinates. Blanking is negative; the active area starts at (0,0).
- Timing set and sync polarity are loaded through a valid/ready config port and take effect only at a frame boundary.
- Adds a frame counter and a programmable line-compare interrupt for the spectrum renderer.

Parameters:
- CORDW, 16, width of the signed coordinate outputs and the unsigned config fields.
- FCW, 16, frame counter width.
- H_RES / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, reset-time horizontal timing.
- V_RES / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, reset-time vertical timing.
- H_POL / V_POL, 0 / 0, reset-time sync polarity (1 = active-high).

Ports:
- clk_pix  in  1  pixel clock
- rst_pix  in  1  synchronous, active-high reset
- cfg_valid  in  1  config offered
- cfg_ready  out  1  shadow register free
- cfg_h_res, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CORDW each  horizontal timing, unsigned
- cfg_v_res, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CORDW each  vertical timing, unsigned
- cfg_h_pol, cfg_v_pol  in  1 each  sync polarity
- cfg_err  out  1  one-cycle pulse when a config is rejected
- irq_line  in  CORDW  signed line number to compare against
- hsync, vsync  out  1  sync outputs, polarity applied
- de  out  1  data enable
- frame  out  1  start-of-frame strobe
- line  out  1  start-of-line strobe
- line_irq  out  1  compare-line strobe
- sx, sy  out  CORDW  signed screen position
- frame_cnt  out  FCW  completed-frame count

Behaviour:
- Active timing set A (res, fp, sync, bp and pol for each axis) is derived per axis:
  - STA = -(fp+sync+bp)
  - HS_STA = STA+fp
  - HS_END = HS_STA+sync
  - A_END = res-1
- Internal counters x and y:
  - x increments every cycle.
  - When x == H_A_END, x goes to H_STA; y goes to V_STA if y == V_A_END, else y+1.
- All outputs are registered and reflect the x/y of the previous cycle (latency 1):
  - sx/sy = x/y.
  - hsync asserted (at pol) when HS_STA < x <= HS_END; vsync likewise on y.
  - de = (x>=0 && y>=0).
  - frame = (x==H_STA && y==V_STA).
  - line = (x==H_STA).
  - line_irq = (x==H_STA && y==irq_line); never fires if irq_line lies outside V_STA..V_A_END.
- frame_cnt increments, wrapping modulo 2^FCW, in the same cycle the frame strobe is registered high.
- Config handshake:
  - Transfer occurs on cfg_valid && cfg_ready.
  - Validation: reject if any res or sync field is 0, or if res+fp+sync+bp > 2^(CORDW-1)-1 on either axis.
  - On reject: cfg_err = 1 for exactly one cycle, nothing is stored, cfg_ready stays 1.
  - On accept: fields go to a shadow register, cfg_ready = 0 from the next cycle, pending = 1.
- Config application:
  - Applied on the frame wrap cycle (x==H_A_END && y==V_A_END) while pending: A <= shadow, x <= new H_STA, y <= new V_STA, pending cleared, cfg_ready = 1 from the next cycle.
  - A config accepted in the wrap cycle itself is not applied in that cycle; it waits for the following frame wrap.
  - The frame still in progress always completes with the old timing. The first frame strobe after the switch uses the new H_STA/V_STA.
- Reset (any cycle, including mid-frame or with a config pending):
  - Set A from parameters, clear the shadow and pending, x = H_STA, y = V_STA.
  - Outputs: hsync = H_POL?0:1, vsync = V_POL?0:1, de = 0, frame = 0, line = 0, line_irq = 0, cfg_err = 0, cfg_ready = 1, frame_cnt = 0, sx = H_STA, sy = V_STA (defaults: -160, -45).
- Arithmetic: all timing math is signed CORDW-bit. Config fields are zero-extended before negation.

Test Plan:
- Reset, run defaults → outputs in reset state as listed (sx=-160, sy=-45). Line = 800 cycles, frame = 420000 cycles. hsync low for 96 cycles at sx=-143..-48. vsync low for 2 lines at sy=-34..-33. de high for 640 cycles per line on lines 0..479. frame_cnt = 1 after the first strobe.
- Offer 1280x720 (h 1280/110/40/220, v 720/5/5/20, pol 1/1) mid-frame → accepted, cfg_ready=0. The current frame completes at 800x525. The next frame starts at sx=-370, sy=-30. Line = 1650 cycles, frame = 750 lines. hsync high at sx=-259..-220. cfg_ready=1 after the switch.
- Offer a config with cfg_h_sync=0, then another with h_res=32767 → cfg_err pulses once each, cfg_ready stays 1, timing unchanged.
- Config accepted exactly in the frame wrap cycle → the current wrap keeps the old timing; the new timing appears one frame later.
- irq_line=100 → line_irq pulses once per frame, coincident with line while sy=100. irq_line=600 under 480p → no pulse.
- Assert rst_pix for 1 cycle mid-frame with a config pending → all outputs return to reset values, pending is discarded, the 480p sequence restarts, frame_cnt=0.
